// File: rtl/gs_pkg.sv
// Shared types and constants for the GoldenSnitch MEM/WB stage.
package gs_pkg;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_WAIT,
      WB_DRAIN
   } wb_state_e;

   localparam int unsigned REG_ZERO = '0;

endpackage

// File: rtl/gs_wb_timer.sv
// Load-response wait timer: synchronous clear, enable, saturates at TIMEOUT and flags the hit.
module gs_wb_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt;

   assign hit = (cnt == TW'(TIMEOUT));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !hit)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/gs_mem_wb.sv
// MEM/WB stage: retires ALU results directly, waits for LSU load data, drives the single
// register-file write port plus the EX bypass and stall.
module gs_mem_wb
   import gs_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ex_valid_i,
   input  logic               ex_MemRead_i,
   input  logic               ex_RegWrite_i,
   input  logic [RADDR_W-1:0] ex_rd_addr_i,
   input  logic [DATA_W-1:0]  ex_alu_result_i,
   input  logic               flush_i,
   input  logic               lsu_rvalid_i,
   input  logic [DATA_W-1:0]  lsu_rdata_i,
   output logic               stall_o,
   output logic               wb_we_o,
   output logic [RADDR_W-1:0] wb_rd_addr_o,
   output logic [DATA_W-1:0]  wb_rd_data_o,
   output logic               fwd_valid_o,
   output logic [RADDR_W-1:0] fwd_rd_o,
   output logic [DATA_W-1:0]  fwd_data_o,
   output logic [CNT_W-1:0]   retire_cnt_o,
   output logic [CNT_W-1:0]   timeout_cnt_o,
   output logic               err_o
);

   wb_state_e          state, state_nx;
   logic [RADDR_W-1:0] pend_rd;
   logic               pend_we;

   logic               issue_ld, issue_alu;
   logic               capture, tmr_clr, tmr_en, tmr_hit;
   logic               we_nx, err_nx, ret_inc, to_inc;
   logic [RADDR_W-1:0] addr_nx;
   logic [DATA_W-1:0]  data_nx;

   assign issue_ld  = ex_valid_i &  ex_MemRead_i & ~flush_i;
   assign issue_alu = ex_valid_i & ~ex_MemRead_i & ~flush_i;
   assign stall_o   = (state != WB_IDLE) | issue_ld;
   assign tmr_en    = (state != WB_IDLE);

   gs_wb_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk(clk),
      .rst(rst),
      .clr(tmr_clr),
      .en (tmr_en),
      .hit(tmr_hit)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      tmr_clr  = 1'b0;
      we_nx    = 1'b0;
      err_nx   = 1'b0;
      ret_inc  = 1'b0;
      to_inc   = 1'b0;
      addr_nx  = wb_rd_addr_o;
      data_nx  = wb_rd_data_o;

      unique case (state)
         WB_IDLE: begin
            if (issue_ld) begin
               state_nx = WB_WAIT;
               capture  = 1'b1;
               tmr_clr  = 1'b1;
            end else if (issue_alu) begin
               ret_inc = 1'b1;
               we_nx   = ex_RegWrite_i && (ex_rd_addr_i != RADDR_W'(REG_ZERO));
               addr_nx = ex_rd_addr_i;
               data_nx = ex_alu_result_i;
            end
         end
         WB_WAIT: begin
            // A response beats a coincident timeout; a coincident flush only suppresses the write.
            if (lsu_rvalid_i) begin
               state_nx = WB_IDLE;
               if (!flush_i) begin
                  ret_inc = 1'b1;
                  we_nx   = pend_we && (pend_rd != RADDR_W'(REG_ZERO));
                  addr_nx = pend_rd;
                  data_nx = lsu_rdata_i;
               end
            end else if (flush_i) begin
               state_nx = WB_DRAIN;
               tmr_clr  = 1'b1;
            end else if (tmr_hit) begin
               state_nx = WB_IDLE;
               err_nx   = 1'b1;
               to_inc   = 1'b1;
            end
         end
         WB_DRAIN: begin
            if (lsu_rvalid_i || tmr_hit)
               state_nx = WB_IDLE;
         end
         default: state_nx = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= WB_IDLE;
         pend_rd       <= '0;
         pend_we       <= 1'b0;
         wb_we_o       <= 1'b0;
         wb_rd_addr_o  <= '0;
         wb_rd_data_o  <= '0;
         err_o         <= 1'b0;
         retire_cnt_o  <= '0;
         timeout_cnt_o <= '0;
      end else begin
         state   <= state_nx;
         wb_we_o <= we_nx;
         err_o   <= err_nx;
         if (capture) begin
            pend_rd <= ex_rd_addr_i;
            pend_we <= ex_RegWrite_i;
         end
         if (we_nx) begin
            wb_rd_addr_o <= addr_nx;
            wb_rd_data_o <= data_nx;
         end
         if (ret_inc)
            retire_cnt_o <= retire_cnt_o + 1'b1;
         if (to_inc)
            timeout_cnt_o <= timeout_cnt_o + 1'b1;
      end
   end

   assign fwd_valid_o = wb_we_o;
   assign fwd_rd_o    = wb_rd_addr_o;
   assign fwd_data_o  = wb_rd_data_o;

endmodule
